// File: rtl/vx_mem_responder_if.sv
// Memory-side request/response channel between a cache lane and its backing store.
// The master drives requests and consumes responses; the slave is the memory.
interface vx_mem_responder_if #(
    parameter int LINE_SIZE  = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                   mem_req_valid;
    logic                   mem_req_rw;
    logic [LINE_SIZE-1:0]   mem_req_byteen;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic [8*LINE_SIZE-1:0] mem_req_data;
    logic [TAG_WIDTH-1:0]   mem_req_tag;
    logic                   mem_req_ready;

    logic                   mem_rsp_valid;
    logic [8*LINE_SIZE-1:0] mem_rsp_data;
    logic [TAG_WIDTH-1:0]   mem_rsp_tag;
    logic                   mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_responder.sv
// Line-granular backing store: posted byte-masked writes, in-order tagged read
// responses after a fixed latency through a bounded response FIFO.
module vx_mem_responder #(
    parameter int LINE_SIZE  = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter int MEM_LINES  = 256,
    parameter int LATENCY    = 4,
    parameter int QUEUE_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_mem_responder_if.slave    mem_bus,
    output logic [31:0]          perf_reads,
    output logic [31:0]          perf_writes
);
    localparam int DATA_W = 8 * LINE_SIZE;
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CNT_W  = $clog2(QUEUE_SIZE + 1);
    localparam int PTR_W  = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_W-1:0]    mem [MEM_LINES];
    logic [MEM_LINES-1:0] written;

    logic [DATA_W-1:0]    q_data [QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] q_tag  [QUEUE_SIZE];
    logic [LAT_W-1:0]     q_cnt  [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] q_vld;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     outstanding;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [IDX_W-1:0]      req_idx;
    logic                  unused_addr;
    logic                  req_fire;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rsp_valid;
    logic                  rsp_fire;
    logic [DATA_W-1:0]     read_line;
    logic [DATA_W-1:0]     merged_line;

    // Upper address bits alias onto the same storage.
    assign req_addr    = mem_bus.mem_req_addr;
    assign req_idx     = req_addr[IDX_W-1:0];
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W];

    assign mem_bus.mem_req_ready = reset && (outstanding < CNT_W'(QUEUE_SIZE));
    assign req_fire = mem_bus.mem_req_valid && mem_bus.mem_req_ready;
    assign wr_fire  = req_fire && mem_bus.mem_req_rw;
    assign rd_fire  = req_fire && !mem_bus.mem_req_rw;

    assign rsp_valid = q_vld[head] && (q_cnt[head] == '0);
    assign rsp_fire  = rsp_valid && mem_bus.mem_rsp_ready;

    assign mem_bus.mem_rsp_valid = rsp_valid;
    assign mem_bus.mem_rsp_data  = rsp_valid ? q_data[head] : '0;
    assign mem_bus.mem_rsp_tag   = rsp_valid ? q_tag[head]  : '0;

    assign read_line = written[req_idx] ? mem[req_idx] : '0;

    // Unwritten lines start from zero, so their disabled bytes come out zeroed.
    always_comb begin
        // NOTE: default assignment first keeps this purely combinational (no latch).
        merged_line = read_line;
        for (int b = 0; b < LINE_SIZE; b++) begin
            if (mem_bus.mem_req_byteen[b]) begin
                merged_line[8*b +: 8] = mem_bus.mem_req_data[8*b +: 8];
            end
        end
    end

    // NOTE: storage arrays carry no reset; only the written bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[req_idx] <= merged_line;
        end
        if (rd_fire) begin
            q_data[tail] <= read_line;
            q_tag[tail]  <= mem_bus.mem_req_tag;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QUEUE_SIZE - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written     <= '0;
            q_vld       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= '0;
            perf_reads  <= '0;
            perf_writes <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                q_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (q_vld[i] && (q_cnt[i] != '0)) begin
                    q_cnt[i] <= q_cnt[i] - 1'b1;
                end
            end
            if (rsp_fire) begin
                q_vld[head] <= 1'b0;
                head        <= ptr_next(head);
            end
            // A newly pushed slot is never occupied, so its load wins over the countdown.
            if (rd_fire) begin
                q_vld[tail] <= 1'b1;
                q_cnt[tail] <= LAT_W'(LATENCY - 1);
                tail        <= ptr_next(tail);
                perf_reads  <= perf_reads + 1'b1;
            end
            if (wr_fire) begin
                written[req_idx] <= 1'b1;
                perf_writes      <= perf_writes + 1'b1;
            end
            case ({rd_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
